alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares the single-cycle combinational ALU between two requesters (req0: execute/register datapath, req1: address/PC-update path).
- Arbitrates with round-robin priority and accepts operations over valid/ready handshakes.
- Drives the ALU's SrcA/SrcB/ALUControl inputs from registered operands, captures ALUResult/ALUFlags, and returns them on a per-requester response handshake.
- Also holds a sticky "last CMP zero" flag for the condition-check logic.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU's width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req0_op  in  2  00 add, 01 sub, 10 pass B, 11 cmp.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp0_result  out  WIDTH  result value.
- rsp0_zero  out  1  ALU flag captured with the result.
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero: same as requester 0, for requester 1.
- alu_srca  out  WIDTH  to ALU SrcA.
- alu_srcb  out  WIDTH  to ALU SrcB.
- alu_ctrl  out  2  to ALU ALUControl.
- alu_result  in  WIDTH  from ALU ALUResult.
- alu_flag  in  1  from ALU ALUFlags.
- busy  out  1  high in any state other than IDLE.
- cmp_zero_q  out  1  flag from the most recently completed cmp (op 11).
- perf_cnt0  out  16  completed ops for requester 0 (see Optional Feature).
- perf_cnt1  out  16  completed ops for requester 1 (see Optional Feature).

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, priority pointer=0 (req0 favoured).
  - Operand/op/owner registers = 0; rsp_result/rsp_zero registers = 0.
  - All *_ready and *_valid = 0, busy = 0, cmp_zero_q = 0, perf counters = 0.
  - Reset mid-operation discards the op silently; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = the valid requester; if both are valid, the one named by the priority pointer.
  - reqX_ready = 1 combinationally, only for the granted requester and only in IDLE.
  - On accept edge: latch a, b, op, owner=X; go to EXEC.
  - If no requester is valid, stay in IDLE.
- EXEC:
  - alu_srca/alu_srcb/alu_ctrl are driven from the latched registers.
  - At the edge: capture alu_result and alu_flag into the owner's response registers; go to RESP.
  - If latched op==11, cmp_zero_q <= alu_flag at that edge; otherwise cmp_zero_q holds.
- RESP:
  - rspX_valid = 1 for the owner only; result and zero are stable while valid.
  - At an edge with rspX_ready=1: go to IDLE; priority pointer <= the non-owner.
  - rspX_ready=0 stalls indefinitely; the other requester is not served in the meantime.
- Outside EXEC, ALU inputs hold the last latched values (no toggling).
- Latency: accept at edge N; rsp_valid high from cycle after edge N+1. Minimum 3 cycles per op, since IDLE is revisited between ops.
- Arithmetic is performed entirely by the ALU; the block does not modify or extend widths. Wrap-around of add/sub is as the ALU produces it.
- rsp_zero is forwarded from the ALU unchanged; the ALU sets it only for op 11 (0 otherwise).
- Simultaneous valid at reset release: req0 wins.
- A requester dropping valid while not granted: legal, no side effect.
- Back-to-back requests from the same requester while the other is waiting: the other requester wins next (strict alternation under contention).

Optional Feature:
- Macro ALU_REQ_ARBITER_PERF_EN.
- Defined:
  - perf_cnt0/perf_cnt1 increment by 1 on each RESP->IDLE transition for that owner.
  - 16-bit, saturating at 16'hFFFF; reset to 0.
- Undefined: perf_cnt0/perf_cnt1 tied to 16'd0; no counter flops are synthesized.

Test Plan:
- req0 add a=5,b=7, rsp0_ready=1 -> req0_ready high 1 cycle; rsp0_valid 2 cycles after accept; rsp0_result=12, rsp0_zero=0, busy high 2 cycles.
- req1 cmp a=9,b=9, then req1 cmp a=9,b=3 -> rsp1_zero=1 then 0; cmp_zero_q=1 after first, 0 after second.
- Both valid continuously, ops sub 10-4 (req0) and pass B=0xDEAD (req1) -> grants alternate req0,req1,req0...; results 6 and 0xDEAD to correct owners.
- rsp0_ready held 0 for 5 cycles with req1 valid -> rsp0 result stable; req1_ready stays 0 until rsp0 taken.
- Assert reset_n=0 during EXEC -> all outputs 0 immediately; no rsp_valid after release; the next request completes normally.
- With ALU_REQ_ARBITER_PERF_EN: 3 req0 ops, 2 req1 ops -> perf_cnt0=3, perf_cnt1=2. Without the macro: both read 0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//
// Shares one single-cycle combinational ALU between two requesters:
//   req0 : execute/register datapath
//   req1 : address/PC-update path
// Round-robin arbitration in IDLE. The accepted operands and op are held in
// registers that drive the ALU. The ALU result and flag are captured in EXEC
// and returned in RESP on a per-requester valid/ready response handshake.
//
// Ports
//   clk, reset_n                       clock, async active-low reset
//   reqX_valid/ready/a/b/op            operation request handshake (X = 0,1)
//                                      op: 00 add, 01 sub, 10 pass B, 11 cmp
//   rspX_valid/ready/result/zero       response handshake (X = 0,1)
//   alu_srca/alu_srcb/alu_ctrl         to the ALU (held outside EXEC)
//   alu_result/alu_flag                from the ALU
//   busy                               high whenever the FSM is not IDLE
//   cmp_zero_q                         ALU flag from the last completed cmp
//   perf_cnt0/perf_cnt1                completed ops per requester
//
// Build option
//   ALU_REQ_ARBITER_PERF_EN  when defined, perf_cnt0/1 are 16-bit saturating
//                            completion counters. Otherwise they are tied to 0.
// ---------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flag,
  output logic             busy,
  output logic             cmp_zero_q,
  output logic [15:0]      perf_cnt0,
  output logic [15:0]      perf_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [1:0] OP_CMP = 2'b11;

  state_e           state_q;
  logic             prio_q;    // 0: req0 favoured on contention, 1: req1
  logic             owner_q;   // requester whose op is in flight
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rsp0_result_q;
  logic [WIDTH-1:0] rsp1_result_q;
  logic             rsp0_zero_q;
  logic             rsp1_zero_q;

  logic grant1;
  logic accept;
  logic rsp_fire;

  // Grant req1 when it is the only valid requester, or when both are valid
  // and the pointer favours it. The reset_n term keeps ready low while reset
  // is held even if a requester already has valid asserted.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || prio_q);
    req0_ready = reset_n && (state_q == IDLE) && req0_valid && !grant1;
    req1_ready = reset_n && (state_q == IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    rsp_fire   = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
  end

  // NOTE: every register below updates with non-blocking assignments so all
  // of them sample pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      owner_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_zero_q   <= 1'b0;
      cmp_zero_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= grant1 ? req1_a  : req0_a;
            b_q     <= grant1 ? req1_b  : req0_b;
            op_q    <= grant1 ? req1_op : req0_op;
            owner_q <= grant1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (owner_q) begin
            rsp1_result_q <= alu_result;
            rsp1_zero_q   <= alu_flag;
          end else begin
            rsp0_result_q <= alu_result;
            rsp0_zero_q   <= alu_flag;
          end
          if (op_q == OP_CMP) cmp_zero_q <= alu_flag;
          state_q <= RESP;
        end
        RESP: begin
          // Hand priority to the other requester so contention alternates.
          if (rsp_fire) begin
            prio_q  <= ~owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pure decodes of registered state; the ALU inputs hold their last values.
  assign alu_srca    = a_q;
  assign alu_srcb    = b_q;
  assign alu_ctrl    = op_q;
  assign busy        = (state_q != IDLE);
  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) && owner_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_zero   = rsp1_zero_q;

`ifdef ALU_REQ_ARBITER_PERF_EN
  logic [15:0] perf_cnt0_q;
  logic [15:0] perf_cnt1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cnt0_q <= '0;
      perf_cnt1_q <= '0;
    end else if (rsp_fire) begin
      if (!owner_q && (perf_cnt0_q != 16'hFFFF)) perf_cnt0_q <= perf_cnt0_q + 16'd1;
      if (owner_q && (perf_cnt1_q != 16'hFFFF))  perf_cnt1_q <= perf_cnt1_q + 16'd1;
    end
  end

  assign perf_cnt0 = perf_cnt0_q;
  assign perf_cnt1 = perf_cnt1_q;
`else
  assign perf_cnt0 = 16'd0;
  assign perf_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_req_arbiter
//
// Self-checking bench for alu_req_arbiter. The bench plays the ALU itself.
// Inputs are driven on the falling clock edge, and outputs are sampled 1 time
// unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_req_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [1:0]       req0_op;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [1:0]       req1_op;
  logic             rsp0_valid, rsp0_ready, rsp0_zero;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp1_valid, rsp1_ready, rsp1_zero;
  logic [WIDTH-1:0] rsp1_result;
  logic [WIDTH-1:0] alu_srca, alu_srcb, alu_result;
  logic [1:0]       alu_ctrl;
  logic             alu_flag;
  logic             busy, cmp_zero_q;
  logic [15:0]      perf_cnt0, perf_cnt1;

  int checks   = 0;
  int failures = 0;

  alu_req_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .busy(busy), .cmp_zero_q(cmp_zero_q),
    .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
  );

  always #5 clk = ~clk;

  // ---- expected behaviour of an op, from the op encoding -------------------
  function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return b;
      default: return a - b;
    endcase
  endfunction

  function automatic logic ref_zero(input logic [1:0] op,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
    return (op == 2'd3) && (a == b);
  endfunction

  // The ALU seen by the DUT.
  always_comb begin
    alu_result = ref_result(alu_ctrl, alu_srca, alu_srcb);
    alu_flag   = ref_zero(alu_ctrl, alu_srca, alu_srcb);
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] perf_expect(input int n);
`ifdef ALU_REQ_ARBITER_PERF_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n < 0) ? 16'd1 : 16'd0;  // counters absent: always read 0
`endif
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  // Leaves the bench on a falling edge with reset released.
  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One complete op on requester req. Called and returns on a falling edge.
  task automatic do_op(input int req, input logic [1:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp_res, input logic exp_zero,
                       input string name);
    bit got;
    if (req == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else          begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if ((req == 0) ? req0_ready : req1_ready) got = 1'b1;
      @(negedge clk);
    end
    check({name, " accept"}, WIDTH'(got), WIDTH'(1));
    req0_valid = 1'b0; req1_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if ((req == 0) ? rsp0_valid : rsp1_valid) begin
        got = 1'b1;
        check({name, " result"}, (req == 0) ? rsp0_result : rsp1_result, exp_res);
        check({name, " zero"}, WIDTH'((req == 0) ? rsp0_zero : rsp1_zero), WIDTH'(exp_zero));
      end
      @(negedge clk);
    end
    check({name, " rsp"}, WIDTH'(got), WIDTH'(1));
  endtask

  typedef struct {
    int               req;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             cmpz_after;
  } vec_t;

  vec_t vecs[9];

  // ---- random-phase transaction model --------------------------------------
  bit               m_busy;
  int               m_age;      // edges since the op was accepted
  int               m_owner;
  int               m_last;     // requester served last; 1 favours req0 next
  logic [1:0]       m_op;
  logic [WIDTH-1:0] m_res;
  logic             m_zero;
  logic             m_cmpz;
  int               m_perf[2];

  initial begin
    int grants[4];
    int ngr;
    int g;

    vecs[0] = '{0, 2'd0, 32'd5,          32'd7,  32'd12,         1'b0, 1'b0};
    vecs[1] = '{1, 2'd3, 32'd9,          32'd9,  32'd0,          1'b1, 1'b1};
    vecs[2] = '{1, 2'd3, 32'd9,          32'd3,  32'd6,          1'b0, 1'b0};
    vecs[3] = '{0, 2'd1, 32'd10,         32'd4,  32'd6,          1'b0, 1'b0};
    vecs[4] = '{1, 2'd2, 32'd0,          32'hDEAD, 32'hDEAD,     1'b0, 1'b0};
    vecs[5] = '{0, 2'd0, 32'hFFFF_FFFF,  32'd1,  32'd0,          1'b0, 1'b0};
    vecs[6] = '{1, 2'd1, 32'd0,          32'd1,  32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[7] = '{0, 2'd3, 32'd0,          32'd0,  32'd0,          1'b1, 1'b1};
    vecs[8] = '{0, 2'd0, 32'd1,          32'd1,  32'd2,          1'b0, 1'b1};

    // ---- reset state, with both requesters already asserting valid -------
    reset_n = 1'b0;
    idle_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); #1;
    check("rst req0_ready", WIDTH'(req0_ready), '0);
    check("rst req1_ready", WIDTH'(req1_ready), '0);
    check("rst busy", WIDTH'(busy), '0);
    check("rst rsp valids", WIDTH'({rsp0_valid, rsp1_valid}), '0);
    check("rst cmp_zero", WIDTH'(cmp_zero_q), '0);
    check("rst alu_srca", alu_srca, '0);
    check("rst alu ctrl/b", alu_srcb | WIDTH'(alu_ctrl), '0);
    check("rst results", rsp0_result | rsp1_result, '0);
    check("rst perf", WIDTH'({perf_cnt0, perf_cnt1}), '0);
    @(negedge clk);
    reset_n = 1'b1; #1;
    check("release req0 wins", WIDTH'({req0_ready, req1_ready}), WIDTH'(2'b10));
    idle_inputs();

    // ---- single op timing: add 5+7 ----------------------------------------
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 2'd0;
    #1;
    check("t1 ready", WIDTH'(req0_ready), WIDTH'(1));
    check("t1 idle busy", WIDTH'(busy), '0);
    @(negedge clk); #1;
    check("t1 ready 1 cycle", WIDTH'(req0_ready), '0);
    check("t1 exec busy", WIDTH'(busy), WIDTH'(1));
    check("t1 exec rsp0_valid", WIDTH'(rsp0_valid), '0);
    check("t1 srca", alu_srca, 32'd5);
    check("t1 srcb", alu_srcb, 32'd7);
    check("t1 ctrl", WIDTH'(alu_ctrl), '0);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    check("t1 rsp0_valid", WIDTH'(rsp0_valid), WIDTH'(1));
    check("t1 rsp1_valid", WIDTH'(rsp1_valid), '0);
    check("t1 result", rsp0_result, 32'd12);
    check("t1 zero", WIDTH'(rsp0_zero), '0);
    check("t1 resp busy", WIDTH'(busy), WIDTH'(1));
    @(negedge clk); #1;
    check("t1 done valid", WIDTH'(rsp0_valid), '0);
    check("t1 done busy", WIDTH'(busy), '0);
    check("t1 srca holds", alu_srca, 32'd5);
    @(negedge clk);

    // ---- table of single ops ----------------------------------------------
    do_reset();
    foreach (vecs[i]) begin
      do_op(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
            vecs[i].zero, $sformatf("vec%0d", i));
      check($sformatf("vec%0d cmp_zero", i), WIDTH'(cmp_zero_q), WIDTH'(vecs[i].cmpz_after));
    end

    // ---- contention: strict alternation ----------------------------------
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4;     req0_op = 2'd1;
    req1_valid = 1'b1; req1_a = 32'd0;  req1_b = 32'hDEAD;  req1_op = 2'd2;
    grants = '{-1, -1, -1, -1};
    ngr = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (req0_ready && req1_ready) check("alt both ready", 32'd1, 32'd0);
      if (req0_ready && ngr < 4) begin grants[ngr] = 0; ngr++; end
      if (req1_ready && ngr < 4) begin grants[ngr] = 1; ngr++; end
      if (rsp0_valid) check("alt rsp0 result", rsp0_result, 32'd6);
      if (rsp1_valid) check("alt rsp1 result", rsp1_result, 32'hDEAD);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("alt grant%0d", i), WIDTH'(grants[i]), WIDTH'(i % 2));
    idle_inputs();
    repeat (3) @(negedge clk);

    // ---- response stall holds off the other requester ---------------------
    do_reset();
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 2'd0;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 2'd0;
    #1 check("stall req0 grant", WIDTH'(req0_ready), WIDTH'(1));
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall rsp0_valid", WIDTH'(rsp0_valid), WIDTH'(1));
      check("stall rsp0_result", rsp0_result, 32'd3);
      check("stall req1_ready", WIDTH'(req1_ready), '0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk); #1;
    check("stall released", WIDTH'(rsp0_valid), '0);
    check("stall req1 next", WIDTH'(req1_ready), WIDTH'(1));
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    check("stall rsp1_valid", WIDTH'(rsp1_valid), WIDTH'(1));
    check("stall rsp1_result", rsp1_result, 32'd7);
    @(negedge clk);

    // ---- reset during EXEC discards the op ---------------------------------
    do_reset();
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 2'd0;
    #1 check("mid accept", WIDTH'(req1_ready), WIDTH'(1));
    @(negedge clk);
    reset_n = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("mid busy", WIDTH'(busy), '0);
    check("mid rsp valids", WIDTH'({rsp0_valid, rsp1_valid}), '0);
    check("mid alu srca", alu_srca, '0);
    check("mid alu ctrl", WIDTH'(alu_ctrl), '0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 check("mid no rsp", WIDTH'({rsp0_valid, rsp1_valid, busy}), '0);
      @(negedge clk);
    end
    do_op(1, 2'd0, 32'd3, 32'd4, 32'd7, 1'b0, "mid after");

    // ---- performance counters ---------------------------------------------
    do_reset();
    for (int i = 0; i < 3; i++) do_op(0, 2'd0, 32'(i), 32'd1, 32'(i + 1), 1'b0, "perf r0");
    for (int i = 0; i < 2; i++) do_op(1, 2'd2, 32'd0, 32'(i), 32'(i), 1'b0, "perf r1");
    check("perf_cnt0", WIDTH'(perf_cnt0), WIDTH'(perf_expect(3)));
    check("perf_cnt1", WIDTH'(perf_cnt1), WIDTH'(perf_expect(2)));

    // ---- randomized traffic against a transaction model -------------------
    do_reset();
    m_busy = 1'b0; m_age = 0; m_owner = 0; m_last = 1; m_cmpz = 1'b0;
    m_op = '0; m_res = '0; m_zero = 1'b0;
    m_perf[0] = 0; m_perf[1] = 0;
    for (int c = 0; c < 600; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op = 2'($urandom_range(0, 3));
      req1_op = 2'($urandom_range(0, 3));
      req0_a = $urandom;
      req1_a = $urandom;
      req0_b = ($urandom_range(0, 2) == 0) ? req0_a : $urandom;
      req1_b = ($urandom_range(0, 2) == 0) ? req1_a : $urandom;
      rsp0_ready = ($urandom_range(0, 9) < 6);
      rsp1_ready = ($urandom_range(0, 9) < 6);
      #1;
      g = -1;
      if (!m_busy) begin
        if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
      end
      check("rnd req0_ready", WIDTH'(req0_ready), WIDTH'(g == 0));
      check("rnd req1_ready", WIDTH'(req1_ready), WIDTH'(g == 1));
      check("rnd busy", WIDTH'(busy), WIDTH'(m_busy));
      check("rnd rsp0_valid", WIDTH'(rsp0_valid), WIDTH'(m_busy && m_age >= 1 && m_owner == 0));
      check("rnd rsp1_valid", WIDTH'(rsp1_valid), WIDTH'(m_busy && m_age >= 1 && m_owner == 1));
      check("rnd cmp_zero", WIDTH'(cmp_zero_q), WIDTH'(m_cmpz));
      if (m_busy && m_age >= 1) begin
        check("rnd result", (m_owner == 0) ? rsp0_result : rsp1_result, m_res);
        check("rnd zero", WIDTH'((m_owner == 0) ? rsp0_zero : rsp1_zero), WIDTH'(m_zero));
      end
      // Effect of the coming rising edge.
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy  = 1'b1;
          m_age   = 0;
          m_owner = g;
          m_op    = (g == 0) ? req0_op : req1_op;
          m_res   = (g == 0) ? ref_result(req0_op, req0_a, req0_b)
                             : ref_result(req1_op, req1_a, req1_b);
          m_zero  = (g == 0) ? ref_zero(req0_op, req0_a, req0_b)
                             : ref_zero(req1_op, req1_a, req1_b);
        end
      end else if (m_age == 0) begin
        m_age = 1;
        if (m_op == 2'd3) m_cmpz = m_zero;
      end else if ((m_owner == 0) ? rsp0_ready : rsp1_ready) begin
        m_busy = 1'b0;
        m_last = m_owner;
        m_perf[m_owner]++;
      end
      @(negedge clk);
    end
    #1;
    check("rnd perf_cnt0", WIDTH'(perf_cnt0), WIDTH'(perf_expect(m_perf[0])));
    check("rnd perf_cnt1", WIDTH'(perf_cnt1), WIDTH'(perf_expect(m_perf[1])));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
